// File: rtl/cue_shot_controller.sv
// Cue shot sequencer: waits for the table to settle, primes on the cue tip,
// confirms a persistent hit and fires one velocity-stamped shot command.
module cue_shot_controller #(
  parameter int CONFIRM_FRAMES = 2,
  parameter int SETTLE_FRAMES  = 4,
  parameter int VMAX           = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [10:0] front_x,
  input  logic [9:0]  front_y,
  input  logic [2:0]  hit_ball,
  input  logic [10:0] hit_x,
  input  logic [9:0]  hit_y,
  input  logic        balls_moving,
  output logic        cue_ready,
  output logic        shot_valid,
  output logic [2:0]  shot_ball,
  output logic [10:0] shot_x,
  output logic [9:0]  shot_y,
  output logic [11:0] shot_vx,
  output logic [10:0] shot_vy,
  output logic [7:0]  shot_count,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    WAIT_STOP = 2'd0,
    ARMED     = 2'd1,
    CONFIRM   = 2'd2,
    FIRE      = 2'd3
  } st_t;

  localparam logic signed [11:0] VX_MAX = 12'(VMAX);
  localparam logic signed [11:0] VX_MIN = -VX_MAX;
  localparam logic signed [10:0] VY_MAX = 11'(VMAX);
  localparam logic signed [10:0] VY_MIN = -VY_MAX;

  st_t         state_q, state_d;
  logic [3:0]  settle_q, settle_d;
  logic [3:0]  conf_q, conf_d;
  logic        primed_q, primed_d;
  logic [10:0] prev_x_q, prev_x_d;
  logic [9:0]  prev_y_q, prev_y_d;
  logic [2:0]  lat_ball_q, lat_ball_d;
  logic [10:0] lat_x_q, lat_x_d;
  logic [9:0]  lat_y_q, lat_y_d;
  logic [11:0] lat_vx_q, lat_vx_d;
  logic [10:0] lat_vy_q, lat_vy_d;
  logic        cue_ready_q, cue_ready_d;
  logic        shot_valid_q, shot_valid_d;
  logic [2:0]  shot_ball_q, shot_ball_d;
  logic [10:0] shot_x_q, shot_x_d;
  logic [9:0]  shot_y_q, shot_y_d;
  logic [11:0] shot_vx_q, shot_vx_d;
  logic [10:0] shot_vy_q, shot_vy_d;
  logic [7:0]  shot_count_q, shot_count_d;

  logic signed [11:0] dx, vx;
  logic signed [10:0] dy, vy;

  // Zero-extended subtraction keeps the full pixel range representable.
  always_comb begin
    dx = $signed({1'b0, front_x}) - $signed({1'b0, prev_x_q});
    dy = $signed({1'b0, front_y}) - $signed({1'b0, prev_y_q});
    vx = (dx > VX_MAX) ? VX_MAX : ((dx < VX_MIN) ? VX_MIN : dx);
    vy = (dy > VY_MAX) ? VY_MAX : ((dy < VY_MIN) ? VY_MIN : dy);
  end

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    conf_d       = conf_q;
    primed_d     = primed_q;
    prev_x_d     = prev_x_q;
    prev_y_d     = prev_y_q;
    lat_ball_d   = lat_ball_q;
    lat_x_d      = lat_x_q;
    lat_y_d      = lat_y_q;
    lat_vx_d     = lat_vx_q;
    lat_vy_d     = lat_vy_q;
    shot_valid_d = 1'b0;
    shot_ball_d  = shot_ball_q;
    shot_x_d     = shot_x_q;
    shot_y_d     = shot_y_q;
    shot_vx_d    = shot_vx_q;
    shot_vy_d    = shot_vy_q;
    shot_count_d = shot_count_q;
    unique case (state_q)
      WAIT_STOP: begin
        if (frame_tick) begin
          if (balls_moving) begin
            settle_d = 4'd0;
          end else begin
            settle_d = settle_q + 4'd1;
            if (settle_d == 4'(SETTLE_FRAMES)) begin
              state_d  = ARMED;
              primed_d = 1'b0;
              settle_d = 4'd0;
            end
          end
        end
      end
      ARMED: begin
        if (frame_tick) begin
          if (balls_moving) begin
            state_d  = WAIT_STOP;
            settle_d = 4'd0;
          end else if (!primed_q || hit_ball == 3'd0) begin
            primed_d = 1'b1;
            prev_x_d = front_x;
            prev_y_d = front_y;
          end else begin
            lat_ball_d = hit_ball;
            lat_x_d    = hit_x;
            lat_y_d    = hit_y;
            lat_vx_d   = vx;
            lat_vy_d   = vy;
            // A hit with no tip motion is a cue resting on the ball.
            if (vx == 12'sd0 && vy == 11'sd0) begin
              prev_x_d = front_x;
              prev_y_d = front_y;
            end else if (CONFIRM_FRAMES == 1) begin
              state_d = FIRE;
            end else begin
              state_d = CONFIRM;
              conf_d  = 4'd1;
            end
          end
        end
      end
      CONFIRM: begin
        if (frame_tick) begin
          if (hit_ball == lat_ball_q) begin
            conf_d = conf_q + 4'd1;
            if (conf_d == 4'(CONFIRM_FRAMES)) state_d = FIRE;
          end else begin
            state_d    = ARMED;
            primed_d   = 1'b1;
            prev_x_d   = front_x;
            prev_y_d   = front_y;
            lat_ball_d = 3'd0;
            lat_x_d    = 11'd0;
            lat_y_d    = 10'd0;
            lat_vx_d   = 12'd0;
            lat_vy_d   = 11'd0;
          end
        end
      end
      FIRE: begin
        state_d  = WAIT_STOP;
        settle_d = 4'd0;
      end
    endcase
    if (state_d == FIRE) begin
      shot_valid_d = 1'b1;
      shot_ball_d  = lat_ball_d;
      shot_x_d     = lat_x_d;
      shot_y_d     = lat_y_d;
      shot_vx_d    = lat_vx_d;
      shot_vy_d    = lat_vy_d;
      shot_count_d = shot_count_q + 8'd1;
    end
    cue_ready_d = (state_d == ARMED) && primed_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT_STOP;
      settle_q     <= 4'd0;
      conf_q       <= 4'd0;
      primed_q     <= 1'b0;
      prev_x_q     <= 11'd0;
      prev_y_q     <= 10'd0;
      lat_ball_q   <= 3'd0;
      lat_x_q      <= 11'd0;
      lat_y_q      <= 10'd0;
      lat_vx_q     <= 12'd0;
      lat_vy_q     <= 11'd0;
      cue_ready_q  <= 1'b0;
      shot_valid_q <= 1'b0;
      shot_ball_q  <= 3'd0;
      shot_x_q     <= 11'd0;
      shot_y_q     <= 10'd0;
      shot_vx_q    <= 12'd0;
      shot_vy_q    <= 11'd0;
      shot_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      conf_q       <= conf_d;
      primed_q     <= primed_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      lat_ball_q   <= lat_ball_d;
      lat_x_q      <= lat_x_d;
      lat_y_q      <= lat_y_d;
      lat_vx_q     <= lat_vx_d;
      lat_vy_q     <= lat_vy_d;
      cue_ready_q  <= cue_ready_d;
      shot_valid_q <= shot_valid_d;
      shot_ball_q  <= shot_ball_d;
      shot_x_q     <= shot_x_d;
      shot_y_q     <= shot_y_d;
      shot_vx_q    <= shot_vx_d;
      shot_vy_q    <= shot_vy_d;
      shot_count_q <= shot_count_d;
    end
  end

  assign state      = state_q;
  assign cue_ready  = cue_ready_q;
  assign shot_valid = shot_valid_q;
  assign shot_ball  = shot_ball_q;
  assign shot_x     = shot_x_q;
  assign shot_y     = shot_y_q;
  assign shot_vx    = shot_vx_q;
  assign shot_vy    = shot_vy_q;
  assign shot_count = shot_count_q;

endmodule

// File: tb/tb_cue_shot_controller.sv
// Directed bench for cue_shot_controller: arming, confirm/abort,
// saturation, resting cue, count wrap and asynchronous reset.
module tb_cue_shot_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic [10:0] front_x;
  logic [9:0]  front_y;
  logic [2:0]  hit_ball;
  logic [10:0] hit_x;
  logic [9:0]  hit_y;
  logic        balls_moving;
  logic        cue_ready;
  logic        shot_valid;
  logic [2:0]  shot_ball;
  logic [10:0] shot_x;
  logic [9:0]  shot_y;
  logic [11:0] shot_vx;
  logic [10:0] shot_vy;
  logic [7:0]  shot_count;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  cue_shot_controller dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .front_x(front_x), .front_y(front_y),
    .hit_ball(hit_ball), .hit_x(hit_x), .hit_y(hit_y),
    .balls_moving(balls_moving), .cue_ready(cue_ready),
    .shot_valid(shot_valid), .shot_ball(shot_ball),
    .shot_x(shot_x), .shot_y(shot_y),
    .shot_vx(shot_vx), .shot_vy(shot_vy),
    .shot_count(shot_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge after the tick edge.
  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic settle();
    balls_moving = 1'b0;
    hit_ball = 3'd0;
    repeat (4) tick();
  endtask

  task automatic quick_shot();
    settle();
    front_x = 11'd100; front_y = 10'd100;
    tick();
    front_x = 11'd110; hit_ball = 3'd1;
    tick();
    tick();
    @(negedge clk);
    hit_ball = 3'd0;
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0;
    front_x = '0; front_y = '0;
    hit_ball = '0; hit_x = '0; hit_y = '0;
    balls_moving = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ready", 32'(cue_ready), 32'd0);
    chk("rst_valid", 32'(shot_valid), 32'd0);
    chk("rst_count", 32'(shot_count), 32'd0);

    // Settle with ticks every 100 cycles.
    front_x = 11'd500; front_y = 10'd300;
    repeat (3) begin
      tick();
      repeat (99) @(negedge clk);
    end
    chk("settle3_state", 32'(state), 32'd0);
    tick();
    chk("settle4_state", 32'(state), 32'd1);
    repeat (99) @(negedge clk);
    chk("unprimed_ready", 32'(cue_ready), 32'd0);
    tick();
    chk("primed_ready", 32'(cue_ready), 32'd1);

    // Shot: prev=(500,300) front=(510,296)
    front_x = 11'd510; front_y = 10'd296;
    hit_ball = 3'd1; hit_x = 11'd505; hit_y = 10'd298;
    tick();
    chk("confirm_state", 32'(state), 32'd2);
    chk("confirm_novalid", 32'(shot_valid), 32'd0);
    tick();
    chk("fire_state", 32'(state), 32'd3);
    chk("fire_valid", 32'(shot_valid), 32'd1);
    chk("fire_ball", 32'(shot_ball), 32'd1);
    chk("fire_x", 32'(shot_x), 32'd505);
    chk("fire_y", 32'(shot_y), 32'd298);
    chk("fire_vx", 32'(shot_vx), 32'h00A);
    chk("fire_vy", 32'(shot_vy), 32'h7FC);
    chk("fire_count", 32'(shot_count), 32'd1);
    hit_ball = 3'd0;
    @(negedge clk);
    chk("post_fire_valid", 32'(shot_valid), 32'd0);
    chk("post_fire_state", 32'(state), 32'd0);

    // Hit then drop-out aborts back to ARMED
    settle();
    front_x = 11'd500; front_y = 10'd300;
    tick();
    front_x = 11'd520; hit_ball = 3'd2;
    tick();
    chk("abort_confirm", 32'(state), 32'd2);
    front_x = 11'd0; hit_ball = 3'd0;
    tick();
    chk("abort_state", 32'(state), 32'd1);
    chk("abort_ready", 32'(cue_ready), 32'd1);
    chk("abort_valid", 32'(shot_valid), 32'd0);
    chk("abort_count", 32'(shot_count), 32'd1);
    chk("abort_hold_x", 32'(shot_x), 32'd505);

    // Positive saturation: 0 -> 1000
    front_x = 11'd1000; hit_ball = 3'd3;
    tick();
    tick();
    chk("satp_valid", 32'(shot_valid), 32'd1);
    chk("satp_ball", 32'(shot_ball), 32'd3);
    chk("satp_vx", 32'(shot_vx), 32'h0FF);
    chk("satp_vy", 32'(shot_vy), 32'h000);
    chk("satp_count", 32'(shot_count), 32'd2);
    hit_ball = 3'd0;
    @(negedge clk);

    // Negative saturation: 1000 -> 0
    settle();
    front_x = 11'd1000;
    tick();
    front_x = 11'd0; hit_ball = 3'd4;
    tick();
    tick();
    chk("satn_valid", 32'(shot_valid), 32'd1);
    chk("satn_vx", 32'(shot_vx), 32'hF01);
    chk("satn_count", 32'(shot_count), 32'd3);
    hit_ball = 3'd0;
    @(negedge clk);

    // Resting cue: hit with no motion stays ARMED
    settle();
    front_x = 11'd200; front_y = 10'd100;
    tick();
    hit_ball = 3'd5;
    tick();
    chk("rest_state", 32'(state), 32'd1);
    chk("rest_ready", 32'(cue_ready), 32'd1);
    hit_ball = 3'd0; balls_moving = 1'b1;
    tick();
    chk("moving_state", 32'(state), 32'd0);
    chk("moving_ready", 32'(cue_ready), 32'd0);

    // Count wrap
    repeat (252) quick_shot();
    chk("count_255", 32'(shot_count), 32'd255);
    settle();
    front_x = 11'd100; front_y = 10'd100;
    tick();
    front_x = 11'd110; hit_ball = 3'd6;
    tick();
    tick();
    chk("wrap_valid", 32'(shot_valid), 32'd1);
    chk("wrap_count", 32'(shot_count), 32'd0);
    hit_ball = 3'd0;
    @(negedge clk);

    // Asynchronous reset in CONFIRM, mid-cycle
    settle();
    front_x = 11'd100;
    tick();
    front_x = 11'd300; hit_ball = 3'd7;
    tick();
    chk("pre_rst_state", 32'(state), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_count", 32'(shot_count), 32'd0);
    chk("arst_x", 32'(shot_x), 32'd0);
    chk("arst_vx", 32'(shot_vx), 32'd0);
    chk("arst_ball", 32'(shot_ball), 32'd0);
    chk("arst_ready", 32'(cue_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    hit_ball = 3'd0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
